// File: rtl/zsy_spi_slave_rx_pkg.sv
// Shared constants for the SPI mode-0 responder: default word width,
// synchronizer depth, idle fill word and FSM state encoding.
package zsy_spi_slave_rx_pkg;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_FILL = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/zsy_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection
// taken from the last two stages.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   rise_c     : one-cycle pulse, synchronized 0->1 transition
//   fall_c     : one-cycle pulse, synchronized 1->0 transition
module zsy_sync_edge
  import zsy_spi_slave_rx_pkg::*;
#(
  parameter int unsigned STAGES  = SPI_SYNC_STAGES,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; bit 0 is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign rise_c =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall_c = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/zsy_spi_slave_rx.sv
// SPI mode-0 (CPOL=0, CPHA=0) responder, MSB first, full duplex. Pins are
// oversampled in the clk domain (f_sclk <= f_clk/8). A one-deep holding
// register feeds the TX shifter; IDLE_FILL is sent when it is empty.
//   spi_en                      : bus enable, low = ignore/abort
//   spi_sclk/spi_cs_n/spi_mosi  : asynchronous SPI pins from the master
//   spi_miso, spi_miso_oe       : slave data out and pad output enable
//   tx_data/tx_valid/tx_ready   : holding register write handshake
//   rx_data/rx_valid            : received word and one-cycle update pulse
//   tx_underrun                 : pulse, IDLE_FILL loaded into the shifter
//   frame_err                   : pulse, cs_n rose with a partial word
//   busy                        : frame in progress
module zsy_spi_slave_rx
  import zsy_spi_slave_rx_pkg::*;
#(
  parameter int unsigned       DATA_W      = SPI_DATA_W,
  parameter int unsigned       SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(SPI_IDLE_FILL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_en,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t state_q, state_d;

  logic              sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic [SYNC_STAGES-2:0] mosi_q;
  logic              mosi_s;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Shifters drop the bit that lives elsewhere: rx keeps the first
  // DATA_W-1 bits, tx keeps the bits still to follow the one on spi_miso.
  logic [DATA_W-2:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-2:0] tx_sh_q, tx_sh_d;
  logic              skip_q, skip_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;

  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d, under_d, ferr_d, miso_d, oe_d;
  logic              load_c;
  logic [DATA_W-1:0] load_word_c;
  logic [DATA_W-1:0] rx_word_c;
  logic              word_done_c;

  zsy_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  zsy_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_cs_n),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  // MOSI is one stage shorter so it lines up with the newer sclk stage
  // used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '1;
    end else begin
      mosi_q[0] <= spi_mosi;
      for (int i = 1; i < int'(SYNC_STAGES) - 1; i++) mosi_q[i] <= mosi_q[i-1];
    end
  end
  assign mosi_s = mosi_q[SYNC_STAGES-2];

  assign load_word_c = hold_full_q ? hold_data_q : IDLE_FILL;
  assign rx_word_c   = {rx_sh_q, mosi_s};
  assign word_done_c = sclk_rise_c && (cnt_q == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (spi_en && cs_fall_c)    state_d = ST_ACTIVE;
      ST_ACTIVE: if (!spi_en || cs_rise_c)   state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    skip_d      = skip_q;
    miso_d      = spi_miso;
    oe_d        = spi_miso_oe;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    under_d     = 1'b0;
    ferr_d      = 1'b0;
    load_c      = 1'b0;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (spi_en && cs_fall_c) begin
          load_c = 1'b1;
          cnt_d  = '0;
          oe_d   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!spi_en) begin
          oe_d   = 1'b0;
          miso_d = 1'b0;
          cnt_d  = '0;
          skip_d = 1'b0;
        end else begin
          if (sclk_rise_c) begin
            rx_sh_d = rx_word_c[DATA_W-2:0];
            if (cnt_q == LAST_BIT) begin
              cnt_d      = '0;
              rx_data_d  = rx_word_c;
              rx_valid_d = 1'b1;
              // No next word if the frame closes on this same edge.
              load_c     = !cs_rise_c;
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
              skip_d = 1'b0;
            end
          end else if (sclk_fall_c) begin
            // The first falling edge after a reload keeps the MSB already shown.
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              miso_d  = tx_sh_q[DATA_W-2];
              tx_sh_d = tx_sh_q << 1;
            end
          end
          if (cs_rise_c) begin
            oe_d   = 1'b0;
            miso_d = 1'b0;
            cnt_d  = '0;
            skip_d = 1'b0;
            ferr_d = !word_done_c && (sclk_rise_c || (cnt_q != '0));
          end
        end
      end
      default: ;
    endcase

    if (load_c) begin
      miso_d  = load_word_c[DATA_W-1];
      tx_sh_d = load_word_c[DATA_W-2:0];
      skip_d  = 1'b1;
      under_d = !hold_full_q;
      if (hold_full_q) hold_full_d = 1'b0;
    end

    // Accept only when empty at the start of the cycle: no valid->ready path.
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      skip_q      <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      skip_q      <= skip_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      tx_underrun <= under_d;
      frame_err   <= ferr_d;
      spi_miso    <= miso_d;
      spi_miso_oe <= oe_d;
      tx_ready    <= !hold_full_d;
      busy        <= (state_d == ST_ACTIVE);
    end
  end

endmodule
